// File: rtl/axi_chk_pkg.sv
// Shared types, error codes and helpers for the AXI1 read-path checker.
package axi_chk_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitData = 2'd1,
    StData     = 2'd2,
    StDone     = 2'd3
  } chk_state_e;

  localparam logic [1:0] ERR_DATA  = 2'd0;
  localparam logic [1:0] ERR_LAST  = 2'd1;
  localparam logic [1:0] ERR_ADDR  = 2'd2;
  localparam logic [1:0] ERR_PROTO = 2'd3;

  // Up to three errors can land in one cycle; the counter sticks at all-ones.
  function automatic logic [15:0] sat_add16(logic [15:0] a, logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/axi_chk_wdog.sv
// Watchdog counter: counts enabled cycles, pulses expire on the TIMEOUT-th one.
module axi_chk_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned     CntW  = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_limit;

  always_comb begin
    at_limit = (cnt_q == Limit);
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !at_limit) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign expire_o = en_i & ~clr_i & at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi1_rd_check.sv
// Passive AXI1 read checker: snoops AR/R, checks addresses, data ramp and RLAST,
// counts errors, captures the first failure and raises sticky pass/fail/timeout.
module axi1_rd_check
  import axi_chk_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       BURST_LEN  = 16,
  parameter int unsigned       NUM_BURSTS = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0800_0000,
  parameter logic [ADDR_W-1:0] ADDR_STEP  = 32'h800,
  parameter logic [DATA_W-1:0] DATA_SEED  = '0,
  parameter int unsigned       TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rlast,
  input  logic              rvalid,
  input  logic              rready,
  output logic [7:0]        burst_cnt,
  output logic [15:0]       err_cnt,
  output logic              first_err_valid,
  output logic [1:0]        first_err_code,
  output logic [7:0]        first_err_burst,
  output logic [7:0]        first_err_beat,
  output logic [DATA_W-1:0] first_err_data,
  output logic              pass,
  output logic              fail,
  output logic              timeout
);

  localparam logic [7:0] LastBeat  = 8'(BURST_LEN - 1);
  localparam logic [7:0] NumBursts = 8'(NUM_BURSTS);

  chk_state_e        state_q, state_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] addr_off_q, addr_off_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              fe_valid_q, fe_valid_d;
  logic [1:0]        fe_code_q, fe_code_d;
  logic [7:0]        fe_burst_q, fe_burst_d;
  logic [7:0]        fe_beat_q, fe_beat_d;
  logic [DATA_W-1:0] fe_data_q, fe_data_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;

  logic              ar_hs, r_hs;
  logic [ADDR_W-1:0] exp_addr, next_addr;
  logic [DATA_W-1:0] exp_data;
  logic              in_burst;
  logic              err_data, err_last, err_addr, err_proto;
  logic [1:0]        n_err;
  logic              pass_done;
  logic              wdog_clr, wdog_en, wdog_expire;

  assign ar_hs     = arvalid & arready;
  assign r_hs      = rvalid & rready;
  assign exp_addr  = BASE_ADDR + addr_off_q;
  assign next_addr = exp_addr + ADDR_STEP;
  assign exp_data  = DATA_SEED + DATA_W'(beat_q);
  // Beats past the expected last one are only drained until RLAST, never checked.
  assign in_burst  = (beat_q <= LastBeat);

  axi_chk_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (wdog_clr),
    .en_i    (wdog_en),
    .expire_o(wdog_expire)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    burst_cnt_d = burst_cnt_q;
    addr_off_d  = addr_off_q;
    err_cnt_d   = err_cnt_q;
    fe_valid_d  = fe_valid_q;
    fe_code_d   = fe_code_q;
    fe_burst_d  = fe_burst_q;
    fe_beat_d   = fe_beat_q;
    fe_data_d   = fe_data_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    err_data    = 1'b0;
    err_last    = 1'b0;
    err_addr    = 1'b0;
    err_proto   = 1'b0;
    n_err       = 2'd0;
    pass_done   = 1'b0;
    wdog_clr    = 1'b1;
    wdog_en     = 1'b0;

    if (clear) begin
      state_d     = StIdle;
      beat_d      = '0;
      burst_cnt_d = '0;
      addr_off_d  = '0;
      err_cnt_d   = '0;
      fe_valid_d  = 1'b0;
      fe_code_d   = '0;
      fe_burst_d  = '0;
      fe_beat_d   = '0;
      fe_data_d   = '0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ar_hs) begin
            state_d  = StWaitData;
            beat_d   = '0;
            err_addr = (araddr != exp_addr);
          end
        end
        StWaitData, StData: begin
          wdog_clr = r_hs;
          wdog_en  = ~r_hs;
          if (r_hs) begin
            err_data = in_burst && (rdata != exp_data);
            err_last = in_burst && (rlast ? (beat_q != LastBeat) : (beat_q == LastBeat));
            state_d  = StData;
            beat_d   = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
            if (rlast) begin
              beat_d      = '0;
              burst_cnt_d = burst_cnt_q + 8'd1;
              addr_off_d  = addr_off_q + ADDR_STEP;
              if (burst_cnt_d == NumBursts) begin
                state_d   = StDone;
                pass_done = 1'b1;
              end else if (ar_hs) begin
                // AR alongside the closing beat opens the next burst directly.
                state_d  = StWaitData;
                err_addr = (araddr != next_addr);
              end else begin
                state_d = StIdle;
              end
            end else if (ar_hs) begin
              err_proto = 1'b1;
            end
          end else if (ar_hs) begin
            err_proto = 1'b1;
          end
          if (wdog_expire) begin
            state_d   = StDone;
            timeout_d = 1'b1;
            fail_d    = 1'b1;
            pass_d    = 1'b0;
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase

      n_err     = 2'(err_data) + 2'(err_last) + 2'(err_addr) + 2'(err_proto);
      err_cnt_d = sat_add16(err_cnt_q, n_err);

      if ((n_err != 2'd0) && !fe_valid_q) begin
        fe_valid_d = 1'b1;
        if (err_data || err_last) begin
          fe_code_d  = err_data ? ERR_DATA : ERR_LAST;
          fe_burst_d = burst_cnt_q;
          fe_beat_d  = beat_q;
          fe_data_d  = rdata;
        end else if (err_addr) begin
          fe_code_d  = ERR_ADDR;
          fe_burst_d = burst_cnt_d;
          fe_beat_d  = '0;
          fe_data_d  = DATA_W'(araddr);
        end else begin
          fe_code_d  = ERR_PROTO;
          fe_burst_d = burst_cnt_q;
          fe_beat_d  = beat_q;
          fe_data_d  = DATA_W'(araddr);
        end
      end

      if (pass_done) begin
        pass_d = (err_cnt_d == 16'd0);
        fail_d = (err_cnt_d != 16'd0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      burst_cnt_q <= '0;
      addr_off_q  <= '0;
      err_cnt_q   <= '0;
      fe_valid_q  <= 1'b0;
      fe_code_q   <= '0;
      fe_burst_q  <= '0;
      fe_beat_q   <= '0;
      fe_data_q   <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      burst_cnt_q <= burst_cnt_d;
      addr_off_q  <= addr_off_d;
      err_cnt_q   <= err_cnt_d;
      fe_valid_q  <= fe_valid_d;
      fe_code_q   <= fe_code_d;
      fe_burst_q  <= fe_burst_d;
      fe_beat_q   <= fe_beat_d;
      fe_data_q   <= fe_data_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
    end
  end

  assign burst_cnt       = burst_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_code  = fe_code_q;
  assign first_err_burst = fe_burst_q;
  assign first_err_beat  = fe_beat_q;
  assign first_err_data  = fe_data_q;
  assign pass            = pass_q;
  assign fail            = fail_q;
  assign timeout         = timeout_q;

endmodule

// File: doc/axi1_rd_check.md
Name: axi1_rd_check

Overview:
- Passive checker downstream of the AXI1 write/read traffic generator.
- Snoops the AR handshake and consumes the R-channel beats the DDR read path returns to that generator.
- Checks burst addresses, incrementing data pattern and RLAST placement; keeps error counters and captures the first failure.
- Sticky pass/fail/timeout flags drive board LEDs and the debug register bank.
- Never drives AXI signals; rready is an input (generator-owned).

Parameters:
- DATA_W, 64, R data width
- ADDR_W, 32, AR address width
- BURST_LEN, 16, beats per burst
- NUM_BURSTS, 8, bursts per pass
- BASE_ADDR, 32'h0800_0000, address of burst 0
- ADDR_STEP, 32'h800, address increment per burst
- DATA_SEED, 0, expected value of beat 0 in every burst
- TIMEOUT, 1024, cycles without an R handshake before timeout

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous pulse: return to IDLE, zero all status
- araddr  in  ADDR_W  snooped AR address
- arvalid  in  1  snooped
- arready  in  1  snooped
- rdata  in  DATA_W  snooped R data
- rlast  in  1  snooped
- rvalid  in  1  snooped
- rready  in  1  snooped
- burst_cnt  out  8  bursts completed this pass
- err_cnt  out  16  errors, saturating at 16'hFFFF
- first_err_valid  out  1  sticky
- first_err_code  out  2  0 data, 1 last, 2 addr, 3 protocol
- first_err_burst  out  8  burst index of the first error
- first_err_beat  out  8  beat index of the first error
- first_err_data  out  DATA_W  observed data (addr errors: araddr zero-extended)
- pass  out  1  sticky
- fail  out  1  sticky
- timeout  out  1  sticky

Behaviour:
- Reset: all outputs 0; state IDLE; beat counter, watchdog and expected-address register 0.
- Handshakes: AR = arvalid & arready; R = rvalid & rready. All outputs registered; updated the cycle after the causing handshake.
- IDLE -> WAIT_DATA on AR.
  - Expected address for burst n = BASE_ADDR + n*ADDR_STEP.
  - Mismatch: addr error; burst still checked.
- WAIT_DATA -> DATA on the first R; this beat is checked as beat 0.
- DATA, each R at beat k:
  - Expected data = DATA_SEED + k, modulo 2^DATA_W. Mismatch: data error.
  - rlast with k != BURST_LEN-1: last error; burst ends.
  - No rlast at k = BURST_LEN-1: last error; beats are still accepted, without data check, until rlast.
  - On rlast: burst_cnt+1, beat counter cleared.
  - If burst_cnt reaches NUM_BURSTS: go to DONE; pass = (err_cnt==0), fail = !pass. Otherwise go to IDLE.
- AR in WAIT_DATA or DATA before rlast: protocol error; address ignored.
- AR in the same cycle as the final rlast: accepted as the next burst (direct to WAIT_DATA).
- Error accounting:
  - Multiple errors on one beat (data + last) count as 2.
  - first_err_* records the lowest code of the first erroring cycle only.
- Watchdog:
  - Increments in WAIT_DATA/DATA on cycles without R; cleared on R.
  - At TIMEOUT: timeout=1, fail=1, go to DONE.
- R beats in IDLE/DONE are ignored. AR in DONE is ignored.
- clear: same-cycle priority over any handshake. Goes to IDLE; counters, flags and capture zeroed. Beats of an interrupted burst are ignored.
- burst_cnt does not wrap: NUM_BURSTS must be <= 255.

Decomposition:
- Package axi_chk_pkg:
  - state enum IDLE/WAIT_DATA/DATA/DONE
  - error-code constants ERR_DATA, ERR_LAST, ERR_ADDR, ERR_PROTO
- Sub-module axi_chk_wdog: loadable watchdog counter with expiry pulse. Everything else stays flat.

Test Plan:
- 8 clean bursts (addr 0x0800_0000..0x0800_3800, data 0..15, rlast on beat 15) -> pass=1, fail=0, burst_cnt=8, err_cnt=0.
- Burst 2, beat 5 returns 0xDEAD -> err_cnt=1, fail=1 after 8 bursts, first_err code 0, burst 2, beat 5, data 0xDEAD.
- rlast on beat 9 of burst 0 -> err_cnt=1, code 1, burst_cnt advances; 14-beat-later traffic unaffected.
- Burst 3 AR at 0x0800_2000 -> code 2, first_err_data=0x0800_2000; beats still checked.
- rvalid held low 1024 cycles after AR -> timeout=1, fail=1, state DONE.
- clear at beat 7 of burst 1, then 8 clean bursts -> pass=1, err_cnt=0, leftover beats ignored.
